ntt_stream_engine: RTL and testbench

//  Parametrised modular NTT engine: y[i] = (sum_j x[j]*omega^(i*j)) mod Q, i,j in 0..N-1.

---
 rtl/ntt_stream_engine_pkg.sv | 23 ++
 rtl/ntt_stream_engine_mod_mul.sv | 27 ++
 rtl/ntt_stream_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ntt_stream_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_stream_engine_pkg.sv
// Shared types and helpers for the streaming NTT engine.
package ntt_stream_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  // Widest word the helpers support; callers zero-extend into it.
  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t q);
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/ntt_stream_engine_mod_mul.sv
// Registered modular multiplier: p = (a*b) mod Q, one cycle of latency.
module ntt_stream_engine_mod_mul #(
  parameter int            DW = 64,
  parameter logic [DW-1:0] Q  = 64'hFFFF_FFFF_0000_0001
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] p_o
);

  logic [2*DW-1:0] prod_d;
  logic [DW-1:0]   p_q;

  always_comb begin
    prod_d = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) p_q <= '0;
    else       p_q <= DW'(prod_d % {{DW{1'b0}}, Q});
  end

  assign p_o = p_q;

endmodule

// File: rtl/ntt_stream_engine.sv
// Streaming NTT: loads x[0..N-1], builds twiddles on chip from omega, computes
// P output rows per block, optionally scales by n_inv, then drains y in order.
module ntt_stream_engine
  import ntt_stream_engine_pkg::*;
#(
  parameter int            N  = 64,
  parameter int            DW = 64,
  parameter logic [DW-1:0] Q  = 64'hFFFF_FFFF_0000_0001,
  parameter int            P  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DW-1:0]        omega_i,
  input  logic                 inv_i,
  input  logic [DW-1:0]        n_inv_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_data_o,
  output logic [$clog2(N)-1:0] out_idx_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  localparam int            IDX_W = $clog2(N);
  localparam int            CW    = $clog2(N + 3);
  localparam int            NBLK  = N / P;
  localparam int            RW    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int            PCW   = $clog2(P + 1);
  localparam logic [DW-1:0] ONE   = {{(DW-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [DW-1:0]    omega_q, ninv_q, omegap_q;
  logic             inv_q;
  logic [DW-1:0]    x_q[N];
  logic [DW-1:0]    y_q[N];
  logic [DW-1:0]    step_q[P];
  logic [DW-1:0]    acc_q[P];
  logic [IDX_W-1:0] ld_q;
  logic [CW-1:0]    c_q;
  logic [RW-1:0]    r_q;
  logic [PCW-1:0]   pc_q;
  logic             in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [DW-1:0]    out_data_q;
  logic [IDX_W-1:0] out_idx_q;

  logic          beat;
  logic [DW-1:0] pm_a, pm_p;
  logic [DW-1:0] mp_a[P], mp_b[P], mp_p[P];
  logic [DW-1:0] mt_a[P], mt_b[P], mt_p[P];

  assign beat = in_valid_i & in_ready_q;

  // PREP chains 1, omega, omega^2, ... through the shared multiplier.
  assign pm_a = (pc_q == '0) ? ONE : pm_p;

  ntt_stream_engine_mod_mul #(.DW(DW), .Q(Q)) u_mul_prep (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(pm_a), .b_i(omega_q), .p_o(pm_p)
  );

  // Block cycle c: 0..N-1 stream x[c]; N flushes the last product; N+1 issues
  // the scale and the step advance; N+2 retires both.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      if (c_q == CW'(N + 1)) begin
        mp_a[k] = acc_q[k];
        mp_b[k] = inv_q ? ninv_q : ONE;
        mt_a[k] = step_q[k];
        mt_b[k] = omegap_q;
      end else begin
        mp_a[k] = x_q[c_q[IDX_W-1:0]];
        mp_b[k] = (c_q == '0) ? ONE : mt_p[k];
        mt_a[k] = (c_q == '0) ? ONE : mt_p[k];
        mt_b[k] = step_q[k];
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    ntt_stream_engine_mod_mul #(.DW(DW), .Q(Q)) u_mul_prod (
      .clk_i(clk_i), .rst_i(rst_i), .a_i(mp_a[k]), .b_i(mp_b[k]), .p_o(mp_p[k])
    );
    ntt_stream_engine_mod_mul #(.DW(DW), .Q(Q)) u_mul_tw (
      .clk_i(clk_i), .rst_i(rst_i), .a_i(mt_a[k]), .b_i(mt_b[k]), .p_o(mt_p[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      omega_q     <= '0;
      ninv_q      <= '0;
      omegap_q    <= '0;
      inv_q       <= 1'b0;
      ld_q        <= '0;
      c_q         <= '0;
      r_q         <= '0;
      pc_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      for (int k = 0; k < P; k++) begin
        step_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (beat) begin
            omega_q <= omega_i;
            inv_q   <= inv_i;
            ninv_q  <= n_inv_i;
            x_q[0]  <= in_data_i;
            ld_q    <= IDX_W'(1);
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (beat) begin
            x_q[ld_q] <= in_data_i;
            if (ld_q == IDX_W'(N - 1)) begin
              in_ready_q <= 1'b0;
              pc_q       <= '0;
              state_q    <= S_PREP;
            end else begin
              ld_q <= ld_q + IDX_W'(1);
            end
          end
        end
        S_PREP: begin
          if (pc_q == '0) step_q[0] <= ONE;
          for (int k = 1; k < P; k++)
            if (pc_q == PCW'(k)) step_q[k] <= pm_p;
          if (pc_q == PCW'(P)) begin
            omegap_q <= pm_p;
            c_q      <= '0;
            r_q      <= '0;
            state_q  <= S_COMPUTE;
          end else begin
            pc_q <= pc_q + PCW'(1);
          end
        end
        S_COMPUTE: begin
          for (int k = 0; k < P; k++) begin
            if (c_q == CW'(1))
              acc_q[k] <= mp_p[k];
            else if (c_q >= CW'(2) && c_q <= CW'(N))
              acc_q[k] <= DW'(mod_add(wide_t'(acc_q[k]), wide_t'(mp_p[k]), wide_t'(Q)));
            if (c_q == CW'(N + 2)) begin
              step_q[k]                            <= mt_p[k];
              y_q[IDX_W'(int'(r_q) * P + k)] <= mp_p[k];
            end
          end
          if (c_q == CW'(N + 2)) begin
            c_q <= '0;
            if (r_q == RW'(NBLK - 1)) state_q <= S_DRAIN;
            else                      r_q     <= r_q + RW'(1);
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        S_DRAIN: begin
          // First cycle presents y[0]; afterwards the index moves only on accept.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= y_q[out_idx_q];
            out_last_q  <= (out_idx_q == IDX_W'(N - 1));
          end else if (out_ready_i) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_idx_q   <= '0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              out_idx_q  <= out_idx_q + IDX_W'(1);
              out_data_q <= y_q[out_idx_q + IDX_W'(1)];
              out_last_q <= (out_idx_q == IDX_W'(N - 2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Scoreboard bench: a small N=4/Q=17 engine with hand-computed vectors and a
// default-size P=4 engine checked against a direct O(N^2) NTT.
module tb_ntt_stream_engine;

  localparam logic [63:0] QA      = 64'd17;
  localparam logic [63:0] QB      = 64'hFFFF_FFFF_0000_0001;
  localparam int          NB      = 64;
  localparam int          PB      = 4;
  localparam int          LAT_LIM = (PB + 1) + (NB / PB) * (NB + 3) + 3;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] a_omega = '0, a_n_inv = '0, a_in_data = '0, a_out_data;
  logic        a_inv = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic        a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [1:0]  a_out_idx;

  logic [63:0] b_omega = '0, b_n_inv = '0, b_in_data = '0, b_out_data;
  logic        b_inv = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [5:0]  b_out_idx;

  ntt_stream_engine #(.N(4), .DW(64), .Q(QA), .P(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .omega_i(a_omega), .inv_i(a_inv), .n_inv_i(a_n_inv),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_idx_o(a_out_idx), .out_last_o(a_out_last), .busy_o(a_busy)
  );

  ntt_stream_engine #(.N(NB), .DW(64), .Q(QB), .P(PB)) dut_b (
    .clk_i(clk), .rst_i(rst), .omega_i(b_omega), .inv_i(b_inv), .n_inv_i(b_n_inv),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_idx_o(b_out_idx), .out_last_o(b_out_last), .busy_o(b_busy)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endfunction

  // Monitors: choose out_ready for the coming edge, then judge that edge.
  exp_t        a_e, b_e;
  logic        a_hold = 1'b0, b_hold = 1'b0;
  logic [63:0] a_hd = '0, b_hd = '0;
  logic [1:0]  a_hi = '0;
  logic [5:0]  b_hi = '0;

  always @(negedge clk) begin
    if (rst) begin
      a_out_ready = 1'b0;
      a_hold      = 1'b0;
    end else begin
      if (a_hold) begin
        check("a_stall_valid", 64'(a_out_valid), 64'd1);
        check("a_stall_data", a_out_data, a_hd);
        check("a_stall_idx", 64'(a_out_idx), 64'(a_hi));
      end
      a_out_ready = 1'($urandom_range(0, 1));
      a_hold      = 1'b0;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected_output: actual idx %0d required no output", a_out_idx);
        end else begin
          a_e = qa.pop_front();
          check("a_data", a_out_data, a_e.data);
          check("a_idx", 64'(a_out_idx), 64'(a_e.idx));
          check("a_last", 64'(a_out_last), 64'(a_e.last));
        end
      end else if (a_out_valid) begin
        a_hold = 1'b1;
        a_hd   = a_out_data;
        a_hi   = a_out_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_out_ready = 1'b0;
      b_hold      = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_stall_valid", 64'(b_out_valid), 64'd1);
        check("b_stall_data", b_out_data, b_hd);
        check("b_stall_idx", 64'(b_out_idx), 64'(b_hi));
      end
      b_out_ready = 1'($urandom_range(0, 1));
      b_hold      = 1'b0;
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected_output: actual idx %0d required no output", b_out_idx);
        end else begin
          b_e = qb.pop_front();
          check("b_data", b_out_data, b_e.data);
          check("b_idx", 64'(b_out_idx), 64'(b_e.idx));
          check("b_last", 64'(b_out_last), 64'(b_e.last));
        end
      end else if (b_out_valid) begin
        b_hold = 1'b1;
        b_hd   = b_out_data;
        b_hi   = b_out_idx;
      end
    end
  end

  task automatic push_a(input logic [63:0] y0, input logic [63:0] y1,
                        input logic [63:0] y2, input logic [63:0] y3);
    logic [63:0] ys[4];
    ys = '{y0, y1, y2, y3};
    for (int i = 0; i < 4; i++) qa.push_back('{data: ys[i], idx: 8'(i), last: (i == 3)});
  endtask

  // Config ports carry junk after the first beat; a gapped frame idles every other cycle.
  task automatic send_a(input logic [63:0] om, input logic iv, input logic [63:0] ni,
                        input logic [63:0] x0, input logic [63:0] x1,
                        input logic [63:0] x2, input logic [63:0] x3, input bit gap);
    logic [63:0] xs[4];
    int j;
    int guard;
    xs    = '{x0, x1, x2, x3};
    j     = 0;
    guard = 0;
    while (j < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (gap && (guard % 2 == 1)) begin
        a_in_valid = 1'b0;
        a_in_data  = 64'd5;
      end else begin
        a_in_valid = 1'b1;
        a_in_data  = xs[j];
        a_omega    = (j == 0) ? om : 64'(j * 5 + 2);
        a_inv      = (j == 0) ? iv : ~iv;
        a_n_inv    = (j == 0) ? ni : 64'd3;
        if (a_in_ready) j++;
      end
    end
    check("a_load_in_budget", 64'(j), 64'd4);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = 64'd9;
    check("a_ready_low_after_last", 64'(a_in_ready), 64'd0);
    check("a_busy_after_last", 64'(a_busy), 64'd1);
    repeat (2) @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || a_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_frame_done_in_budget", 64'(n < budget), 64'd1);
    @(negedge clk);
    check("a_ready_idle", 64'(a_in_ready), 64'd1);
    check("a_busy_idle", 64'(a_busy), 64'd0);
  endtask

  function automatic logic [63:0] mulq(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, QB});
  endfunction

  function automatic logic [63:0] addq(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QB}) s = s - {1'b0, QB};
    return s[63:0];
  endfunction

  // 2 has order 192 mod the Goldilocks prime, so 8 = 2^3 is a primitive 64th root.
  task automatic run_b();
    logic [63:0] xb[NB];
    logic [63:0] pw[NB];
    logic [63:0] acc;
    int j;
    int guard;
    int cyc;
    pw[0] = 64'd1;
    for (int k = 1; k < NB; k++) pw[k] = mulq(pw[k-1], 64'd8);
    for (int k = 0; k < NB; k++) xb[k] = {$urandom, $urandom} % QB;
    xb[0] = QB - 64'd1;
    for (int i = 0; i < NB; i++) begin
      acc = '0;
      for (int k = 0; k < NB; k++) acc = addq(acc, mulq(xb[k], pw[(i * k) % NB]));
      qb.push_back('{data: acc, idx: 8'(i), last: (i == NB - 1)});
    end
    j     = 0;
    guard = 0;
    while (j < NB && guard < 500) begin
      @(negedge clk);
      guard++;
      b_in_valid = 1'b1;
      b_in_data  = xb[j];
      b_omega    = (j == 0) ? 64'd8 : 64'(j);
      b_inv      = (j == 0) ? 1'b0 : 1'b1;
      b_n_inv    = 64'd7;
      if (b_in_ready) j++;
    end
    check("b_load_in_budget", 64'(j), 64'(NB));
    @(negedge clk);
    b_in_valid = 1'b0;
    cyc = 1;
    while (!b_out_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("b_compute_latency_ok", 64'(cyc <= LAT_LIM), 64'd1);
    cyc = 0;
    while ((qb.size() != 0 || b_busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("b_drain_in_budget", 64'(cyc < 2000), 64'd1);
    @(negedge clk);
    check("b_ready_idle", 64'(b_in_ready), 64'd1);
  endtask

  initial begin
    @(negedge clk);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_last", 64'(a_out_last), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_out_data", a_out_data, 64'd0);
    check("rst_a_out_idx", 64'(a_out_idx), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("a_ready_after_rst", 64'(a_in_ready), 64'd1);
    check("b_ready_after_rst", 64'(b_in_ready), 64'd1);

    push_a(64'd10, 64'd7, 64'd15, 64'd6);
    send_a(64'd4, 1'b0, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
    wait_done_a(400);

    push_a(64'd1, 64'd2, 64'd3, 64'd4);
    send_a(64'd13, 1'b1, 64'd13, 64'd10, 64'd7, 64'd15, 64'd6, 1'b0);
    wait_done_a(400);

    push_a(64'd13, 64'd0, 64'd0, 64'd0);
    send_a(64'd4, 1'b0, 64'd0, QA - 1, QA - 1, QA - 1, QA - 1, 1'b1);
    wait_done_a(400);

    run_b();

    // Abort: nothing is expected from this frame.
    send_a(64'd4, 1'b0, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(a_in_ready), 64'd0);
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_out_valid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after_rst", 64'(a_in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("abort_no_output", 64'(a_out_valid), 64'd0);

    push_a(64'd10, 64'd7, 64'd15, 64'd6);
    send_a(64'd4, 1'b0, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
    wait_done_a(400);

    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: actual timeout required finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
